// File: rtl/iob_merge2.sv
// Two-master to one-slave arbiter for the native valid/ready memory bus.
// It latches the winning request, holds it towards the slave and routes the response back to the granted master.
module iob_merge2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RR     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ready,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ready,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ready,
  output logic                busy,
  output logic                grant
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic                s_valid_q, s_valid_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
  logic [STRB_W-1:0]   s_wstrb_q, s_wstrb_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;

  logic                pick;
  logic                load;
  logic                load_idx;

  // Arbitration winner among the currently valid masters (only meaningful when one is valid).
  always_comb begin
    if (RR != 0) begin
      if (m0_valid && m1_valid) pick = ~last_q;
      else                      pick = m1_valid;
    end else begin
      pick = ~m0_valid;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_valid_d = s_valid_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wstrb_d = s_wstrb_q;
    grant_d   = grant_q;
    last_d    = last_q;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    load      = 1'b0;
    load_idx  = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          load     = 1'b1;
          load_idx = pick;
        end
      end
      BUSY: begin
        if (s_ready) begin
          if (grant_q) begin
            m1_ready = 1'b1;
            m1_rdata = s_rdata;
          end else begin
            m0_ready = 1'b1;
            m0_rdata = s_rdata;
          end
          last_d = grant_q;
          // The served master's valid is stale this edge, so only the other one may follow back-to-back.
          if (grant_q ? m0_valid : m1_valid) begin
            load     = 1'b1;
            load_idx = ~grant_q;
          end else begin
            s_valid_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        s_valid_d = 1'b0;
      end
    endcase

    if (load) begin
      state_d   = BUSY;
      s_valid_d = 1'b1;
      grant_d   = load_idx;
      s_addr_d  = load_idx ? m1_addr  : m0_addr;
      s_wdata_d = load_idx ? m1_wdata : m0_wdata;
      s_wstrb_d = load_idx ? m1_wstrb : m0_wstrb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      s_valid_q <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      s_valid_q <= s_valid_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wstrb_q <= s_wstrb_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
    end
  end

  assign s_valid = s_valid_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_wstrb = s_wstrb_q;
  assign busy    = s_valid_q;
  assign grant   = grant_q;

endmodule
